// File: rtl/smbm_driver_pkg.sv
// Shared sizes, entry type and opcode encodings used by the SMBM driver and the
// metric manager it talks to.
package smbm_driver_pkg;

    localparam int unsigned BIT_VEC_SIZE       = 256;
    localparam int unsigned BIT_VEC_SIZE_LOG   = 8;
    localparam int unsigned NUM_OF_METRICS     = 8;
    localparam int unsigned NUM_OF_METRICS_LOG = 3;
    localparam int unsigned METRIC_W           = 8;

    typedef struct packed {
        logic [METRIC_W-1:0]         val;
        logic [BIT_VEC_SIZE_LOG-1:0] ptr;
    } entry_t;

    // All-ones marks an empty list slot and the "no data" response entry.
    localparam entry_t ENTRY_NONE = '1;

    typedef enum logic [1:0] {
        ReqAdd      = 2'b00,
        ReqDelete   = 2'b01,
        ReqReadFilt = 2'b10,
        ReqReadAll  = 2'b11
    } req_op_e;

    localparam logic [2:0] SM_OP_ADD    = 3'b000;
    localparam logic [2:0] SM_OP_DELETE = 3'b001;
    localparam logic [2:0] SM_OP_READ   = 3'b010;
    localparam logic [2:0] SM_OP_IDLE   = 3'b111;
    localparam logic [2:0] SM_IN_FILT   = 3'b010;
    localparam logic [2:0] SM_IN_ALL    = 3'b101;

    function automatic logic [2:0] sm_opcode_of(req_op_e op);
        logic [2:0] opc;
        case (op)
            ReqAdd:    opc = SM_OP_ADD;
            ReqDelete: opc = SM_OP_DELETE;
            default:   opc = SM_OP_READ;
        endcase
        return opc;
    endfunction

    function automatic logic [2:0] sm_opcode_in_of(req_op_e op);
        logic [2:0] opc;
        case (op)
            ReqReadFilt: opc = SM_IN_FILT;
            ReqReadAll:  opc = SM_IN_ALL;
            default:     opc = SM_OP_IDLE;
        endcase
        return opc;
    endfunction

endpackage

// File: rtl/priority_encode_log.sv
// Index of the lowest set bit of a vector, plus a flag that any bit is set.
module priority_encode_log #(
    parameter int unsigned WIDTH     = 256,
    parameter int unsigned WIDTH_LOG = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]     vec,
    output logic [WIDTH_LOG-1:0] idx,
    output logic                 valid
);

    always_comb begin
        idx   = '0;
        valid = |vec;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) idx = WIDTH_LOG'(i);
        end
    end

endmodule

// File: rtl/smbm_driver.sv
// Request/response front end for the sorted metric bucket manager: issues one
// manager command per request and streams READ results back one entry at a time.
module smbm_driver
    import smbm_driver_pkg::*;
(
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      req_valid,
    output logic                                      req_ready,
    input  logic [1:0]                                req_op,
    input  logic [BIT_VEC_SIZE_LOG-1:0]               req_id,
    input  logic [NUM_OF_METRICS-1:0][METRIC_W-1:0]   req_metric,
    input  logic [BIT_VEC_SIZE-1:0]                   req_mask,
    input  logic [NUM_OF_METRICS_LOG-1:0]             req_metric_sel,
    output logic [2:0]                                sm_opcode,
    output logic [2:0]                                sm_opcode_in,
    output logic [BIT_VEC_SIZE_LOG-1:0]               sm_id,
    output logic [NUM_OF_METRICS-1:0][METRIC_W-1:0]   sm_metric_val,
    output logic [BIT_VEC_SIZE-1:0]                   sm_in,
    output logic [NUM_OF_METRICS_LOG-1:0]             sm_metricX,
    input  entry_t [BIT_VEC_SIZE-1:0]                 sm_out_list,
    input  logic                                      sm_done,
    output logic                                      rsp_valid,
    input  logic                                      rsp_ready,
    output entry_t                                    rsp_entry,
    output logic                                      rsp_last,
    output logic                                      rsp_err,
    output logic [BIT_VEC_SIZE_LOG:0]                 count
);

    localparam int unsigned TIMEOUT_CYCLES = 16;
    localparam int unsigned TMR_W          = $clog2(TIMEOUT_CYCLES);
    localparam logic [BIT_VEC_SIZE_LOG:0] COUNT_MAX = (BIT_VEC_SIZE_LOG + 1)'(BIT_VEC_SIZE);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StCapture,
        StStream,
        StResp
    } state_e;

    state_e                      state_q, state_d;
    req_op_e                     op_q;
    logic [BIT_VEC_SIZE_LOG:0]   count_q, count_d;
    logic [TMR_W-1:0]            tmr_q, tmr_d;
    logic                        err_q, err_d;
    logic [BIT_VEC_SIZE-1:0]     pending_q, pending_d;
    entry_t [BIT_VEC_SIZE-1:0]   list_q;

    logic [BIT_VEC_SIZE_LOG-1:0] pend_idx;
    logic                        pend_any;
    logic                        pend_one;
    logic                        reject;

    priority_encode_log #(
        .WIDTH (BIT_VEC_SIZE)
    ) u_pend_enc (
        .vec   (pending_q),
        .idx   (pend_idx),
        .valid (pend_any)
    );

    assign req_ready = (state_q == StIdle) && rst_n;
    assign count     = count_q;
    assign pend_one  = pend_any && ((pending_q & (pending_q - 1'b1)) == '0);
    assign reject    = (req_op_e'(req_op) == ReqAdd && count_q == COUNT_MAX) ||
                       (req_op_e'(req_op) == ReqDelete && count_q == '0);

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        tmr_d        = tmr_q;
        err_d        = err_q;
        pending_d    = pending_q;
        sm_opcode    = SM_OP_IDLE;
        sm_opcode_in = SM_OP_IDLE;
        rsp_valid    = 1'b0;
        rsp_last     = 1'b0;
        rsp_err      = 1'b0;
        rsp_entry    = '0;

        unique case (state_q)
            StIdle: begin
                if (req_valid && req_ready) begin
                    err_d   = reject;
                    state_d = reject ? StResp : StIssue;
                end
            end
            StIssue: begin
                sm_opcode    = sm_opcode_of(op_q);
                sm_opcode_in = sm_opcode_in_of(op_q);
                tmr_d        = '0;
                state_d      = StWait;
            end
            StWait: begin
                if (sm_done) begin
                    unique case (op_q)
                        ReqAdd: begin
                            if (count_q != COUNT_MAX) count_d = count_q + 1'b1;
                            state_d = StResp;
                        end
                        ReqDelete: begin
                            if (count_q != '0) count_d = count_q - 1'b1;
                            state_d = StResp;
                        end
                        default: state_d = StCapture;
                    endcase
                end else if (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            StCapture: begin
                for (int i = 0; i < BIT_VEC_SIZE; i++) begin
                    pending_d[i] = (sm_out_list[i] != ENTRY_NONE);
                end
                state_d = StStream;
            end
            StStream: begin
                // An empty result still produces a single terminating response.
                rsp_valid = 1'b1;
                rsp_entry = pend_any ? list_q[pend_idx] : ENTRY_NONE;
                rsp_last  = !pend_any || pend_one;
                if (rsp_ready) begin
                    if (pend_any) pending_d[pend_idx] = 1'b0;
                    if (rsp_last) state_d = StIdle;
                end
            end
            StResp: begin
                rsp_valid = 1'b1;
                rsp_last  = 1'b1;
                rsp_entry = ENTRY_NONE;
                rsp_err   = err_q;
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            op_q          <= ReqAdd;
            count_q       <= '0;
            tmr_q         <= '0;
            err_q         <= 1'b0;
            pending_q     <= '0;
            sm_id         <= '0;
            sm_metric_val <= '0;
            sm_in         <= '0;
            sm_metricX    <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            tmr_q     <= tmr_d;
            err_q     <= err_d;
            pending_q <= pending_d;
            if (req_valid && req_ready) begin
                op_q          <= req_op_e'(req_op);
                sm_id         <= req_id;
                sm_metric_val <= req_metric;
                sm_in         <= req_mask;
                sm_metricX    <= req_metric_sel;
            end
        end
    end

    // Result payload needs no reset: it is only read while pending bits are set.
    always_ff @(posedge clk) begin
        if (state_q == StCapture) list_q <= sm_out_list;
    end

endmodule

// File: tb/tb_smbm_driver.sv
// Randomized bench for smbm_driver; the bench plays the manager and predicts
// responses and the resident count from the request rules.
module tb_smbm_driver;
    import smbm_driver_pkg::*;

    localparam int TMO = 16;

    typedef struct {
        entry_t e;
        logic   last;
        logic   err;
    } rsp_t;

    logic                                    clk = 1'b0;
    logic                                    rst_n = 1'b0;
    logic                                    req_valid = 1'b0;
    logic                                    req_ready;
    logic [1:0]                              req_op = '0;
    logic [BIT_VEC_SIZE_LOG-1:0]             req_id = '0;
    logic [NUM_OF_METRICS-1:0][METRIC_W-1:0] req_metric = '0;
    logic [BIT_VEC_SIZE-1:0]                 req_mask = '0;
    logic [NUM_OF_METRICS_LOG-1:0]           req_metric_sel = '0;
    logic [2:0]                              sm_opcode;
    logic [2:0]                              sm_opcode_in;
    logic [BIT_VEC_SIZE_LOG-1:0]             sm_id;
    logic [NUM_OF_METRICS-1:0][METRIC_W-1:0] sm_metric_val;
    logic [BIT_VEC_SIZE-1:0]                 sm_in;
    logic [NUM_OF_METRICS_LOG-1:0]           sm_metricX;
    entry_t [BIT_VEC_SIZE-1:0]               sm_out_list = '1;
    logic                                    sm_done = 1'b0;
    logic                                    rsp_valid;
    logic                                    rsp_ready = 1'b0;
    entry_t                                  rsp_entry;
    logic                                    rsp_last;
    logic                                    rsp_err;
    logic [BIT_VEC_SIZE_LOG:0]               count;

    int     n_vec = 0;
    int     n_err = 0;
    int     model_count = 0;
    entry_t list_m [BIT_VEC_SIZE];
    rsp_t   exp_q [$];

    smbm_driver u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_id         (req_id),
        .req_metric     (req_metric),
        .req_mask       (req_mask),
        .req_metric_sel (req_metric_sel),
        .sm_opcode      (sm_opcode),
        .sm_opcode_in   (sm_opcode_in),
        .sm_id          (sm_id),
        .sm_metric_val  (sm_metric_val),
        .sm_in          (sm_in),
        .sm_metricX     (sm_metricX),
        .sm_out_list    (sm_out_list),
        .sm_done        (sm_done),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_entry      (rsp_entry),
        .rsp_last       (rsp_last),
        .rsp_err        (rsp_err),
        .count          (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic rsp_t mk_rsp(entry_t e, logic last, logic err);
        rsp_t r;
        r.e    = e;
        r.last = last;
        r.err  = err;
        return r;
    endfunction

    function automatic logic [255:0] rand_vec();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Random manager result: each slot occupied with probability dens/8, only
    // inside the mask for filtered reads.
    task automatic gen_list_m(input logic [255:0] mask, input bit filt);
        int dens;
        dens = $urandom_range(0, 3);
        for (int i = 0; i < BIT_VEC_SIZE; i++) begin
            list_m[i] = '1;
            if ((!filt || mask[i]) && $urandom_range(0, 7) < dens) begin
                list_m[i].val = 8'($urandom);
                list_m[i].ptr = 8'($urandom);
                if (list_m[i] === ENTRY_NONE) list_m[i].ptr = '0;
            end
        end
    endtask

    task automatic collect(input int stall);
        int guard;
        int stall_left;
        guard      = 0;
        stall_left = stall;
        while (exp_q.size() > 0 && guard < 1500) begin
            if (rsp_valid) begin
                check("rsp_entry", rsp_entry, exp_q[0].e);
                check("rsp_last", rsp_last, exp_q[0].last);
                check("rsp_err", rsp_err, exp_q[0].err);
                if (stall_left > 0) begin
                    rsp_ready = 1'b0;
                    stall_left--;
                end else begin
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
                if (rsp_ready) void'(exp_q.pop_front());
            end else begin
                rsp_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            guard++;
        end
        check("rsp_outstanding", 256'(exp_q.size()), 256'(0));
        exp_q.delete();
        rsp_ready = 1'b0;
        check("back_idle_ready", req_ready, 1'b1);
        check("back_idle_valid", rsp_valid, 1'b0);
    endtask

    // done_at: WAIT cycle (1..16) in which sm_done is raised; 0 = never.
    task automatic do_op(input logic [1:0] op, input logic [7:0] id, input logic [63:0] metric,
                         input logic [255:0] mask, input int done_at, input int stall,
                         input bit gen_list);
        logic [2:0] sel;
        logic [2:0] exp_opc;
        logic [2:0] exp_opin;
        logic       rej;
        int         nv;
        int         k;
        sel      = 3'($urandom_range(0, 7));
        exp_opc  = (op == 2'd0) ? 3'b000 : (op == 2'd1) ? 3'b001 : 3'b010;
        exp_opin = (op == 2'd2) ? 3'b010 : (op == 2'd3) ? 3'b101 : 3'b111;
        rej      = (op == 2'd0 && model_count == BIT_VEC_SIZE) || (op == 2'd1 && model_count == 0);
        if (gen_list && op[1]) gen_list_m(mask, op == 2'd2);
        for (int i = 0; i < BIT_VEC_SIZE; i++) sm_out_list[i] = list_m[i];

        @(negedge clk);
        req_op         = op;
        req_id         = id;
        req_metric     = metric;
        req_mask       = mask;
        req_metric_sel = sel;
        req_valid      = 1'b1;
        check("req_ready", req_ready, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        req_id    = ~id;
        req_mask  = ~mask;

        if (rej) begin
            check("rej_no_issue", sm_opcode, 3'b111);
            exp_q.push_back(mk_rsp(ENTRY_NONE, 1'b1, 1'b1));
        end else begin
            check("issue_opcode", sm_opcode, exp_opc);
            check("issue_opcode_in", sm_opcode_in, exp_opin);
            check("issue_id", sm_id, id);
            check("issue_metric", sm_metric_val, metric);
            check("issue_mask", sm_in, mask);
            check("issue_sel", sm_metricX, sel);
            for (int j = 1; j <= TMO; j++) begin
                @(negedge clk);
                check("wait_opcode", sm_opcode, 3'b111);
                check("wait_id", sm_id, id);
                check("wait_mask", sm_in, mask);
                check("wait_quiet", rsp_valid, 1'b0);
                if (j == done_at) begin
                    sm_done = 1'b1;
                    break;
                end
            end
            @(negedge clk);
            sm_done = 1'b0;
            if (done_at >= 1 && done_at <= TMO) begin
                if (op == 2'd0) model_count++;
                else if (op == 2'd1) model_count--;
                if (op[1]) begin
                    check("capture_gap", rsp_valid, 1'b0);
                    nv = 0;
                    for (int i = 0; i < BIT_VEC_SIZE; i++) if (list_m[i] !== ENTRY_NONE) nv++;
                    k = 0;
                    for (int i = 0; i < BIT_VEC_SIZE; i++) begin
                        if (list_m[i] !== ENTRY_NONE) begin
                            k++;
                            exp_q.push_back(mk_rsp(list_m[i], k == nv, 1'b0));
                        end
                    end
                    if (nv == 0) exp_q.push_back(mk_rsp(ENTRY_NONE, 1'b1, 1'b0));
                end else begin
                    check("resp_after_done", rsp_valid, 1'b1);
                    exp_q.push_back(mk_rsp(ENTRY_NONE, 1'b1, 1'b0));
                end
            end else begin
                check("timeout_resp", rsp_valid, 1'b1);
                check("timeout_opcode", sm_opcode, 3'b111);
                exp_q.push_back(mk_rsp(ENTRY_NONE, 1'b1, 1'b1));
            end
        end
        collect(stall);
        check("count", count, 256'(model_count));
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] op;
        int r;
        for (int i = 0; i < BIT_VEC_SIZE; i++) list_m[i] = '1;

        // Reset state while rst_n is held low.
        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_opcode", sm_opcode, 3'b111);
        check("rst_opcode_in", sm_opcode_in, 3'b111);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_last", rsp_last, 1'b0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_count", count, 256'(0));
        check("rst_sm_id", sm_id, 256'(0));
        rst_n = 1'b1;

        // DELETE on an empty table is rejected without touching the manager.
        do_op(2'd1, 8'd9, rand_vec(), rand_vec(), 3, 0, 1'b0);
        // ADD id 5 with all metrics 10.
        do_op(2'd0, 8'd5, {8{8'd10}}, '0, 2, 0, 1'b0);
        do_op(2'd0, 8'd6, rand_vec(), '0, 1, 0, 1'b0);
        do_op(2'd0, 8'd7, rand_vec(), '0, 16, 0, 1'b0);
        // Filtered READ with entries 0 and 2 returned.
        for (int i = 0; i < BIT_VEC_SIZE; i++) list_m[i] = '1;
        list_m[0] = '{val: 8'd10, ptr: 8'd0};
        list_m[2] = '{val: 8'd10, ptr: 8'd2};
        do_op(2'd2, 8'd0, rand_vec(), 256'h5, 3, 0, 1'b0);
        // READ whose manager never answers.
        do_op(2'd3, 8'd1, rand_vec(), rand_vec(), 0, 0, 1'b1);
        // Five-cycle back-pressure at the head of a stream.
        do_op(2'd3, 8'd2, rand_vec(), rand_vec(), 4, 5, 1'b1);

        // Reset in the middle of an ADD's WAIT phase.
        @(negedge clk);
        req_op    = 2'd0;
        req_id    = 8'd33;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_count = 0;
        check("midrst_count", count, 256'(0));
        check("midrst_ready", req_ready, 1'b0);
        check("midrst_opcode", sm_opcode, 3'b111);
        check("midrst_valid", rsp_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("postrst_quiet", rsp_valid, 1'b0);
        end
        do_op(2'd0, 8'd34, rand_vec(), '0, 5, 0, 1'b0);

        // Random mix of operations, delays and back-pressure.
        for (int n = 0; n < 40; n++) begin
            r  = $urandom_range(0, 9);
            op = (r < 4) ? 2'd0 : (r < 6) ? 2'd1 : (r < 8) ? 2'd2 : 2'd3;
            do_op(op, 8'($urandom), rand_vec(), rand_vec(),
                  ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TMO),
                  $urandom_range(0, 3), 1'b1);
        end

        // Fill to capacity, then one more ADD must be rejected.
        while (model_count < BIT_VEC_SIZE) do_op(2'd0, 8'(model_count), rand_vec(), '0, 1, 0, 1'b0);
        do_op(2'd0, 8'd200, rand_vec(), '0, 1, 0, 1'b0);
        check("full_count", count, 256'(BIT_VEC_SIZE));
        do_op(2'd1, 8'd200, rand_vec(), '0, 2, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
